// File: rtl/mips_cpu_next_pc_if.sv
// ---------------------------------------------------------------------------
// mips_cpu_next_pc_if
//   Bundle between the control path / PC register and the next-PC generator.
//
//   pc_curr          : current PC (output of the PC register)
//   advance          : instruction at pc_curr completes this cycle
//   redirect_valid   : completing instruction is a taken branch/jump
//   redirect_target  : branch/jump destination, valid with redirect_valid
//   pc_next          : next PC, combinational, feeds the PC register
//   in_delay_slot    : instruction at pc_curr sits in a delay slot
//   slot_violation   : one-cycle pulse, redirect requested from a delay slot
//   addr_error       : sticky misaligned-target flag
//
//   master : the side that owns the PC register and control path
//   slave  : the next-PC generator
// ---------------------------------------------------------------------------
interface mips_cpu_next_pc_if;
    logic [31:0] pc_curr;
    logic        advance;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_next;
    logic        in_delay_slot;
    logic        slot_violation;
    logic        addr_error;

    modport master (
        output pc_curr,
        output advance,
        output redirect_valid,
        output redirect_target,
        input  pc_next,
        input  in_delay_slot,
        input  slot_violation,
        input  addr_error
    );

    modport slave (
        input  pc_curr,
        input  advance,
        input  redirect_valid,
        input  redirect_target,
        output pc_next,
        output in_delay_slot,
        output slot_violation,
        output addr_error
    );
endinterface

// File: rtl/mips_cpu_next_pc.sv
// ---------------------------------------------------------------------------
// mips_cpu_next_pc
//   Next-PC generator with MIPS branch-delay-slot sequencing. Sits directly
//   upstream of the PC register and drives its input every cycle.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset; forces pc_next to RESET_VECTOR
//     bus  : mips_cpu_next_pc_if.slave (pc_curr, advance, redirect_valid,
//            redirect_target in; pc_next, in_delay_slot, slot_violation,
//            addr_error out)
//
//   A taken branch latches its target and lets the delay-slot instruction
//   at pc_curr+4 run; the target is applied on the advance that completes
//   the slot. A misaligned target sends the CPU to HALT_ADDR and latches
//   addr_error until reset. Once pc_curr reaches HALT_ADDR the CPU is
//   parked there and all inputs are ignored.
// ---------------------------------------------------------------------------
module mips_cpu_next_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    mips_cpu_next_pc_if.slave bus
);

    localparam logic [1:0] ST_SEQ  = 2'd0;
    localparam logic [1:0] ST_SLOT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        in_delay_slot_q, in_delay_slot_d;
    logic        slot_violation_q, slot_violation_d;
    logic        addr_error_q, addr_error_d;
    logic [31:0] pc_next_d;

    logic [31:0] pc_seq;
    logic        halted;
    logic        tgt_aligned;

    // +4 wraps modulo 2^32, so FFFFFFFC rolls onto HALT_ADDR when it is 0
    assign pc_seq      = bus.pc_curr + 32'd4;
    assign halted      = (bus.pc_curr == HALT_ADDR);
    assign tgt_aligned = (tgt_q[1:0] == 2'b00);

    always_comb begin
        state_d          = state_q;
        tgt_d            = tgt_q;
        in_delay_slot_d  = in_delay_slot_q;
        slot_violation_d = 1'b0;
        addr_error_d     = addr_error_q;
        pc_next_d        = bus.pc_curr;

        if (rst) begin
            pc_next_d = RESET_VECTOR;
        end else if (halted) begin
            // Parked: state, target and sticky flags frozen; the violation
            // pulse still self-clears.
            pc_next_d = HALT_ADDR;
        end else begin
            case (state_q)
                ST_SEQ: begin
                    if (bus.advance) begin
                        pc_next_d = pc_seq;
                        if (bus.redirect_valid) begin
                            tgt_d           = bus.redirect_target;
                            state_d         = ST_SLOT;
                            in_delay_slot_d = 1'b1;
                        end
                    end
                end
                ST_SLOT: begin
                    if (bus.advance) begin
                        // A redirect from the slot itself is dropped; tgt_q
                        // keeps the original branch destination.
                        slot_violation_d = bus.redirect_valid;
                        in_delay_slot_d  = 1'b0;
                        if (tgt_aligned) begin
                            pc_next_d = tgt_q;
                            state_d   = ST_SEQ;
                        end else begin
                            pc_next_d    = HALT_ADDR;
                            state_d      = ST_ERR;
                            addr_error_d = 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    pc_next_d = bus.pc_curr;
                end
                default: begin
                    state_d         = ST_SEQ;
                    in_delay_slot_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_SEQ;
            tgt_q            <= '0;
            in_delay_slot_q  <= 1'b0;
            slot_violation_q <= 1'b0;
            addr_error_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            tgt_q            <= tgt_d;
            in_delay_slot_q  <= in_delay_slot_d;
            slot_violation_q <= slot_violation_d;
            addr_error_q     <= addr_error_d;
        end
    end

    assign bus.pc_next        = pc_next_d;
    assign bus.in_delay_slot  = in_delay_slot_q;
    assign bus.slot_violation = slot_violation_q;
    assign bus.addr_error     = addr_error_q;

endmodule
